// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode field values, the halt encoding and the
// fetch FSM state type. No ports.
package cpu_pkg;

  localparam logic [2:0] XOR_OP  = 3'd0;
  localparam logic [2:0] BEQ_OP  = 3'd1;
  localparam logic [2:0] ADDI_OP = 3'd2;
  localparam logic [2:0] ANDI_OP = 3'd3;
  localparam logic [2:0] LS_OP   = 3'd4;
  localparam logic [2:0] LD_OP   = 3'd5;
  localparam logic [2:0] ST_OP   = 3'd6;
  localparam logic [2:0] J_OP    = 3'd7;

  // Halt: jump opcode with every operand bit zero.
  localparam logic [8:0] HALT_INSTR = {J_OP, 6'b000000};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    OUT  = 2'd2,
    HALT = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory req/ack link plus the valid/ready
// channel to decode.
//   master : fetch unit (drives imem_req/imem_addr and out_*, takes ack/rdata/out_ready)
//   slave  : memory + decode side (mirror directions)
interface fetch_unit_if #(
  parameter int unsigned PC_W    = 10,
  parameter int unsigned INSTR_W = 9,
  parameter int unsigned OPC_W   = 3
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;
  logic [OPC_W-1:0]   out_opcode;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc, out_opcode,
    input  imem_ack, imem_rdata, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_opcode,
    output imem_ack, imem_rdata, out_ready
  );
endinterface

// File: rtl/fetch_unit_pc_reg.sv
// pc_reg: program counter with parallel load and modulo-2**PC_W increment.
//   clk, reset     : clock, asynchronous active-high reset (to START_PC)
//   load_i         : load load_val_i (start / redirect); wins over inc_i
//   load_val_i     : value to load
//   inc_i          : advance to the next word
//   pc_o           : current PC
module pc_reg #(
  parameter int unsigned PC_W     = 10,
  parameter int unsigned START_PC = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic [PC_W-1:0] load_val_i,
  input  logic            inc_i,
  output logic [PC_W-1:0] pc_o
);
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i)     pc_d = load_val_i;
    else if (inc_i) pc_d = pc_q + PC_W'(1);  // wraps at 2**PC_W
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= PC_W'(START_PC);
    else       pc_q <= pc_d;
  end

  assign pc_o = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, fetches words over the
// variable-latency imem req/ack link and hands one instruction per
// valid/ready handshake to decode. Redirects on execute's taken branch/jump
// and stops after delivering the halt word.
//   clk, reset         : clock, asynchronous active-high reset
//   start              : 1-cycle pulse, begin fetching at START_PC (IDLE/HALT only)
//   bus (master)       : imem_req/addr/ack/rdata, out_valid/ready/instr/pc/opcode
//   redirect(_pc)      : taken branch/jump target from execute
//   done               : halt reached, sticky until start or reset
//   cycle_cnt          : only with FETCH_CYCLE_CNT_EN, saturating REQ/OUT cycle count
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W     = 10,
  parameter int unsigned INSTR_W  = 9,
  parameter int unsigned OPC_W    = 3,
  parameter int unsigned START_PC = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  fetch_unit_if.master    bus,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            done
`ifdef FETCH_CYCLE_CNT_EN
  ,
  output logic [31:0]     cycle_cnt
`endif
);
  localparam logic [INSTR_W-1:0] HALT_WORD = {{OPC_W{1'b1}}, {(INSTR_W-OPC_W){1'b0}}};

  fetch_state_e       state_q;
  logic               req_q;
  logic               drop_q;
  logic               out_valid_q;
  logic               done_q;
  logic [INSTR_W-1:0] out_instr_q;
  logic [PC_W-1:0]    out_pc_q;

  logic               busy;
  logic               take_ack;
  logic               out_fire;
  logic               is_halt;
  logic               pc_load;
  logic [PC_W-1:0]    pc_load_val;
  logic [PC_W-1:0]    pc;

  always_comb begin
    busy        = (state_q == REQ) || (state_q == OUT);
    take_ack    = (state_q == REQ) && !redirect && !drop_q && bus.imem_ack;
    out_fire    = out_valid_q && bus.out_ready;
    is_halt     = (out_instr_q == HALT_WORD);
    pc_load     = (!busy && start) || (busy && redirect);
    pc_load_val = busy ? redirect_pc : PC_W'(START_PC);
  end

  pc_reg #(
    .PC_W     (PC_W),
    .START_PC (START_PC)
  ) u_pc_reg (
    .clk        (clk),
    .reset      (reset),
    .load_i     (pc_load),
    .load_val_i (pc_load_val),
    .inc_i      (take_ack),
    .pc_o       (pc)
  );

  // drop_q marks the one-cycle gap after a redirect: imem_req is low and any
  // ack seen then belongs to the abandoned request. An ack coinciding with the
  // redirect itself is already excluded by take_ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      drop_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE, HALT: begin
          if (start) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            drop_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        REQ: begin
          if (redirect) begin
            req_q  <= 1'b0;
            drop_q <= 1'b1;
          end else if (drop_q) begin
            req_q  <= 1'b1;
            drop_q <= 1'b0;
          end else if (take_ack) begin
            req_q       <= 1'b0;
            out_valid_q <= 1'b1;
            out_instr_q <= bus.imem_rdata;
            out_pc_q    <= pc;
            state_q     <= OUT;
          end
        end
        OUT: begin
          // A handshake in the same cycle as a redirect simply retires the
          // word; the redirect then restarts fetching at the target.
          if (redirect) begin
            out_valid_q <= 1'b0;
            req_q       <= 1'b0;
            drop_q      <= 1'b1;
            state_q     <= REQ;
          end else if (out_fire) begin
            out_valid_q <= 1'b0;
            if (is_halt) begin
              state_q <= HALT;
              done_q  <= 1'b1;
            end else begin
              state_q <= REQ;
              req_q   <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = pc;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_instr  = out_instr_q;
  assign bus.out_pc     = out_pc_q;
  assign bus.out_opcode = out_instr_q[INSTR_W-1 -: OPC_W];
  assign done           = done_q;

`ifdef FETCH_CYCLE_CNT_EN
  logic [31:0] cycle_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt_q <= '0;
    end else if (!busy && start) begin
      cycle_cnt_q <= '0;
    end else if (busy && (cycle_cnt_q != '1)) begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: imem responder and decode scoreboard are
// evaluated once per cycle just before the rising edge; expected words are
// queued when a program is loaded and popped on each valid/ready handshake.
module tb_fetch_unit;
  import cpu_pkg::*;

  typedef struct {
    logic [9:0] pc;
    logic [8:0] instr;
    logic [2:0] opc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       redirect;
  logic [9:0] redirect_pc;
  logic       done;
`ifdef FETCH_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;
`endif

  logic [8:0]  mem [0:1023];
  bit          auto_mem;
  int unsigned mem_wait;
  int unsigned wait_cnt;
  exp_t        sb [$];
  int          checks = 0;
  int          errors = 0;

  fetch_unit_if #(.PC_W(10), .INSTR_W(9), .OPC_W(3)) bus ();

  fetch_unit #(
    .PC_W     (10),
    .INSTR_W  (9),
    .OPC_W    (3),
    .START_PC (0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .bus         (bus),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .done        (done)
`ifdef FETCH_CYCLE_CNT_EN
    ,
    .cycle_cnt   (cycle_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: memory model + scoreboard on the inputs about to be sampled,
  // then advance to 1 time unit after the rising edge.
  task automatic cyc();
    exp_t e;
    if (auto_mem) begin
      if (bus.imem_req) begin
        if (wait_cnt >= mem_wait) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = mem[bus.imem_addr];
          wait_cnt       = 0;
        end else begin
          bus.imem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        bus.imem_ack = 1'b0;
        wait_cnt     = 0;
      end
    end
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_extra observed pc=%0h expected no output", bus.out_pc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_pc",     32'(bus.out_pc),     32'(e.pc));
        check("sb_instr",  32'(bus.out_instr),  32'(e.instr));
        check("sb_opcode", 32'(bus.out_opcode), 32'(e.opc));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [9:0] pc, input logic [8:0] instr, input logic [2:0] opc);
    exp_t e;
    e.pc = pc; e.instr = instr; e.opc = opc;
    mem[pc] = instr;
    sb.push_back(e);
  endtask

  task automatic run_until_done(input string tag, input int unsigned budget);
    for (int unsigned i = 0; i < budget && done !== 1'b1; i++) cyc();
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 9'h001;
    reset          = 1'b1;
    start          = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = '0;
    auto_mem       = 1'b0;
    mem_wait       = 0;
    wait_cnt       = 0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    bus.out_ready  = 1'b1;

    // Reset state
    cyc(); cyc();
    check("rst_req",       32'(bus.imem_req),  32'd0);
    check("rst_addr",      32'(bus.imem_addr), 32'd0);
    check("rst_valid",     32'(bus.out_valid), 32'd0);
    check("rst_instr",     32'(bus.out_instr), 32'd0);
    check("rst_pc",        32'(bus.out_pc),    32'd0);
    check("rst_done",      32'(done),          32'd0);
    reset = 1'b0;
    cyc();

    // 1: reset in the middle of a request, late ack must be ignored
    start = 1'b1; cyc(); start = 1'b0;
    check("t1_req_up", 32'(bus.imem_req), 32'd1);
    reset = 1'b1; cyc();
    reset = 1'b0;
    bus.imem_ack = 1'b1; bus.imem_rdata = 9'h050; cyc();
    bus.imem_ack = 1'b0; cyc();
    check("t1_valid", 32'(bus.out_valid), 32'd0);
    check("t1_req",   32'(bus.imem_req),  32'd0);
    check("t1_pc",    32'(bus.imem_addr), 32'd0);

    // 2: three-word halt program, zero-wait memory
    auto_mem = 1'b1; mem_wait = 0;
    push(10'h000, 9'h050, BEQ_OP);
    push(10'h001, 9'h0A3, ADDI_OP);
    push(10'h002, HALT_INSTR, J_OP);
    start = 1'b1; cyc(); start = 1'b0;
    run_until_done("t2", 40);
`ifdef FETCH_CYCLE_CNT_EN
    check("t6_cnt", cycle_cnt, 32'd6);
`endif
    cyc(); cyc(); cyc();
    check("t2_done_sticky", 32'(done),         32'd1);
    check("t2_halt_noreq",  32'(bus.imem_req), 32'd0);
`ifdef FETCH_CYCLE_CNT_EN
    check("t6_cnt_frozen", cycle_cnt, 32'd6);
`endif

    // 3: backpressure on pc=3 with one-wait-state memory
    mem_wait = 1;
    push(10'h000, 9'h111, LS_OP);
    push(10'h001, 9'h14A, LD_OP);
    push(10'h002, 9'h18C, ST_OP);
    push(10'h003, 9'h02B, XOR_OP);
    push(10'h004, HALT_INSTR, J_OP);
    start = 1'b1; cyc(); start = 1'b0;
    for (int unsigned i = 0; i < 60 && !(bus.out_valid === 1'b1 && bus.out_pc === 10'h003); i++) cyc();
    check("t3_reach_valid", 32'(bus.out_valid), 32'd1);
    check("t3_reach_pc",    32'(bus.out_pc),    32'h003);
    bus.out_ready = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      cyc();
      check("t3_hold_valid", 32'(bus.out_valid), 32'd1);
      check("t3_hold_instr", 32'(bus.out_instr), 32'h02B);
      check("t3_hold_pc",    32'(bus.out_pc),    32'h003);
      check("t3_hold_noreq", 32'(bus.imem_req),  32'd0);
    end
    bus.out_ready = 1'b1;
    run_until_done("t3", 40);
    mem_wait = 0;

    // 4: redirect with ack in the same cycle and a stray ack the cycle after
    auto_mem = 1'b0; bus.imem_ack = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    check("t4_req_up", 32'(bus.imem_req), 32'd1);
    bus.imem_ack = 1'b1; bus.imem_rdata = 9'h0EE;
    redirect = 1'b1; redirect_pc = 10'h040;
    cyc();
    redirect = 1'b0;
    check("t4_gap_req",   32'(bus.imem_req),  32'd0);
    check("t4_gap_addr",  32'(bus.imem_addr), 32'h040);
    check("t4_gap_valid", 32'(bus.out_valid), 32'd0);
    cyc();
    bus.imem_ack = 1'b0;
    check("t4_drop_valid", 32'(bus.out_valid), 32'd0);
    check("t4_req_again",  32'(bus.imem_req),  32'd1);
    check("t4_addr_again", 32'(bus.imem_addr), 32'h040);
    push(10'h040, 9'h0B5, ADDI_OP);
    push(10'h041, HALT_INSTR, J_OP);
    auto_mem = 1'b1;
    run_until_done("t4", 40);

    // 5: PC wraps from 10'h3FF to 10'h000
    mem[10'h000] = HALT_INSTR;
    push(10'h3FF, 9'h0C7, ANDI_OP);
    push(10'h000, HALT_INSTR, J_OP);
    start = 1'b1; cyc(); start = 1'b0;
    redirect = 1'b1; redirect_pc = 10'h3FF; cyc(); redirect = 1'b0;
    for (int unsigned i = 0; i < 20 && bus.out_valid !== 1'b1; i++) cyc();
    check("t5_pc_top", 32'(bus.out_pc), 32'h3FF);
    cyc();
    check("t5_wrap_req",  32'(bus.imem_req),  32'd1);
    check("t5_wrap_addr", 32'(bus.imem_addr), 32'h000);
    run_until_done("t5", 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
